// File: rtl/mskbitop_hpc2_seq_if.sv
// rtl/mskbitop_hpc2_seq_if.sv - operand, randomness and result handshakes of the masked bit-op sequencer
// Share i of every word sits at [i*W +: W]; rnd carries one bit per unordered share pair.
interface mskbitop_hpc2_seq_if #(
  parameter int d = 2,
  parameter int W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_op;
  logic [d*W-1:0]         in_a;
  logic [d*W-1:0]         in_b;
  logic [d*(d-1)/2-1:0]   rnd;
  logic                   rnd_valid;
  logic                   rnd_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [d*W-1:0]         out_c;
  logic                   busy;

  modport master (
    output in_valid, in_op, in_a, in_b, rnd, rnd_valid, out_ready,
    input  in_ready, rnd_ready, out_valid, out_c, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, rnd, rnd_valid, out_ready,
    output in_ready, rnd_ready, out_valid, out_c, busy
  );
endinterface

// File: rtl/mskbitop_hpc2_seq.sv
// rtl/mskbitop_hpc2_seq.sv - bit-serial masked AND/OR sequencer around a pipelined 1-bit HPC2 gadget
// Optional feature macro: MSKBITOP_OR_EN (De Morgan OR via share-0 inversion).
module mskbitop_hpc2_gadget #(
  parameter int d   = 2,
  parameter int LAT = 2
) (
  input  logic                 clk,
  input  logic [d-1:0]         a,
  input  logic [d-1:0]         b,
  input  logic [d*(d-1)/2-1:0] r,
  output logic [d-1:0]         c
);
  localparam int EXTRA = (LAT > 2) ? LAT - 2 : 0;

  // Symmetric randomness matrix with a zero diagonal: the i==j term then reduces to a_i&b_i.
  logic [d-1:0] rmat [d];
  logic [d-1:0] c_raw;

  for (genvar i = 0; i < d; i++) begin : g_ri
    for (genvar j = 0; j < d; j++) begin : g_rj
      if (i < j) begin : g_up
        assign rmat[i][j] = r[i*d - (i*(i+1))/2 + j - i - 1];
      end else if (i > j) begin : g_lo
        assign rmat[i][j] = r[j*d - (j*(j+1))/2 + i - j - 1];
      end else begin : g_dg
        assign rmat[i][j] = 1'b0;
      end
    end
  end

  if (LAT == 1) begin : g_one
    logic [d-1:0] u_q [d];
    logic [d-1:0] p_q [d];
    always_ff @(posedge clk) begin
      for (int i = 0; i < d; i++) begin
        u_q[i] <= ~{d{a[i]}} & rmat[i];
        p_q[i] <= {d{a[i]}} & (b ^ rmat[i]);
      end
    end
    for (genvar i = 0; i < d; i++) begin : g_c
      assign c_raw[i] = ^(u_q[i] ^ p_q[i]);
    end
  end else begin : g_two
    logic [d-1:0] a_q;
    logic [d-1:0] u_q  [d];
    logic [d-1:0] v_q  [d];
    logic [d-1:0] u2_q [d];
    logic [d-1:0] p_q  [d];
    always_ff @(posedge clk) begin
      a_q <= a;
      for (int i = 0; i < d; i++) begin
        u_q[i]  <= ~{d{a[i]}} & rmat[i];
        v_q[i]  <= b ^ rmat[i];
        u2_q[i] <= u_q[i];
        p_q[i]  <= {d{a_q[i]}} & v_q[i];
      end
    end
    for (genvar i = 0; i < d; i++) begin : g_c
      assign c_raw[i] = ^(u2_q[i] ^ p_q[i]);
    end
  end

  if (EXTRA == 0) begin : g_nodly
    assign c = c_raw;
  end else begin : g_dly
    logic [d-1:0] dly [EXTRA];
    always_ff @(posedge clk) begin
      dly[0] <= c_raw;
      for (int k = 1; k < EXTRA; k++) dly[k] <= dly[k-1];
    end
    assign c = dly[EXTRA-1];
  end
endmodule

module mskbitop_hpc2_seq #(
  parameter int d   = 2,
  parameter int W   = 8,
  parameter int LAT = 2
) (
  input logic                   clk,
  input logic                   rst,
  mskbitop_hpc2_seq_if.slave    bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   issue_cnt, collect_cnt;
  logic [LAT-1:0]  vpipe;
  logic [W-1:0]    a_sh [d];
  logic [W-1:0]    b_sh [d];
  logic [W-1:0]    c_sh [d];
  logic [d-1:0]    slice_a, slice_b, g_c, inv;
  logic [W-1:0]    ld_inv;
  logic            load, slice_go, tail;

  assign tail = vpipe[LAT-1];

  for (genvar i = 0; i < d; i++) begin : g_sh
    assign slice_a[i] = a_sh[i][0];
    assign slice_b[i] = b_sh[i][0];
    assign bus.out_c[i*W +: W] = c_sh[i];
  end

`ifdef MSKBITOP_OR_EN
  logic op_q;
  assign ld_inv = {W{bus.in_op}};
  assign inv    = {{(d-1){1'b0}}, op_q};
`else
  logic unused_op;
  assign unused_op = bus.in_op;
  assign ld_inv    = '0;
  assign inv       = '0;
`endif

  mskbitop_hpc2_gadget #(.d(d), .LAT(LAT)) u_gadget (
    .clk (clk),
    .a   (slice_a),
    .b   (slice_b),
    .r   (bus.rnd),
    .c   (g_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      collect_cnt <= '0;
      vpipe       <= '0;
      for (int i = 0; i < d; i++) begin
        a_sh[i] <= '0;
        b_sh[i] <= '0;
        c_sh[i] <= '0;
      end
`ifdef MSKBITOP_OR_EN
      op_q <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      // The gadget has no enable, so the marker pipe advances on every edge.
      vpipe <= LAT'({vpipe, slice_go});
      if (load) begin
        for (int i = 0; i < d; i++) begin
          a_sh[i] <= bus.in_a[i*W +: W];
          b_sh[i] <= bus.in_b[i*W +: W];
        end
        a_sh[0]     <= bus.in_a[W-1:0] ^ ld_inv;
        b_sh[0]     <= bus.in_b[W-1:0] ^ ld_inv;
        issue_cnt   <= '0;
        collect_cnt <= '0;
`ifdef MSKBITOP_OR_EN
        op_q <= bus.in_op;
`endif
      end else if (slice_go) begin
        for (int i = 0; i < d; i++) begin
          a_sh[i] <= a_sh[i] >> 1;
          b_sh[i] <= b_sh[i] >> 1;
        end
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (tail) begin
        for (int i = 0; i < d; i++) begin
          for (int k = 0; k < W; k++) begin
            if (collect_cnt == CW'(k)) c_sh[i][k] <= g_c[i] ^ inv[i];
          end
        end
        collect_cnt <= collect_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    slice_go = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load     = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.rnd_valid) begin
          slice_go = 1'b1;
          if (issue_cnt == CW'(W - 1)) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (tail && collect_cnt == CW'(W - 1)) state_nx = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.rnd_ready = slice_go;
endmodule
